// File: rtl/fml_arb2.sv
// -----------------------------------------------------------------------------
// fml_arb2 -- two-port FML arbiter.
//
// Shares the single FML port of the SDRAM controller between two FML masters
// (port 0: framebuffer reader, port 1: Wishbone-to-FML bridge). A grant covers
// a whole transaction: the request phase up to the controller ack plus the
// burst_len-beat data phase that follows it. Contested requests are resolved
// round-robin, with port 0 winning the first contest after reset.
//
// Ports:
//   clk_sys_i, rst_i        system clock, asynchronous active-high reset
//   m0_* / m1_*             master ports: adr, stb, we, sel, do in; ack, di out
//   s_*                     controller port: adr, stb, we, sel, do out; ack, di in
// -----------------------------------------------------------------------------
module fml_arb2 #(
  parameter int sdram_depth = 26,
  parameter int burst_len   = 4
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_i,

  input  logic [sdram_depth-1:0] m0_adr,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  output logic                   m0_ack,
  input  logic [3:0]             m0_sel,
  input  logic [31:0]            m0_do,
  output logic [31:0]            m0_di,

  input  logic [sdram_depth-1:0] m1_adr,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  output logic                   m1_ack,
  input  logic [3:0]             m1_sel,
  input  logic [31:0]            m1_do,
  output logic [31:0]            m1_di,

  output logic [sdram_depth-1:0] s_adr,
  output logic                   s_stb,
  output logic                   s_we,
  input  logic                   s_ack,
  output logic [3:0]             s_sel,
  output logic [31:0]            s_do,
  input  logic [31:0]            s_di
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [3:0] last_beat = 4'(burst_len - 1);

  state_e     state_q, state_d;
  logic       grant_q, grant_d;   // port currently owning the controller
  logic       last_q,  last_d;    // port that completed the most recent request
  logic       we_q,    we_d;      // write enable captured at ack, held over the burst
  logic [3:0] cnt_q,   cnt_d;     // data beat counter

  // Signals of whichever master currently holds the grant.
  logic                   g_stb;
  logic                   g_we;
  logic [sdram_depth-1:0] g_adr;
  logic [3:0]             g_sel;
  logic [31:0]            g_do;

  always_comb begin
    g_stb = grant_q ? m1_stb : m0_stb;
    g_we  = grant_q ? m1_we  : m0_we;
    g_adr = grant_q ? m1_adr : m0_adr;
    g_sel = grant_q ? m1_sel : m0_sel;
    g_do  = grant_q ? m1_do  : m0_do;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every _d signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    we_d    = we_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (m0_stb || m1_stb) begin
          state_d = REQ;
          // Contest goes to the port that did not win the previous one.
          if (m0_stb && m1_stb) grant_d = ~last_q;
          else                  grant_d = m1_stb;
        end
      end
      REQ: begin
        if (s_ack) begin
          last_d  = grant_q;
          we_d    = g_we;
          cnt_d   = '0;
          state_d = DATA;
        end else if (!g_stb) begin
          // Master withdrew its request without being acked; release the port.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q == last_beat) state_d = IDLE;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to 1 so that port 0 wins the first contest.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controller-side outputs and acks. Acks reach only the granted master and
  // only in REQ, so a stray s_ack in IDLE or DATA is never forwarded.
  always_comb begin
    s_stb  = 1'b0;
    s_adr  = '0;
    s_we   = 1'b0;
    s_sel  = '0;
    s_do   = '0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;

    case (state_q)
      REQ: begin
        s_stb  = g_stb;
        s_adr  = g_adr;
        s_we   = g_we;
        m0_ack = s_ack & ~grant_q;
        m1_ack = s_ack &  grant_q;
      end
      DATA: begin
        s_we  = we_q;
        s_sel = g_sel;
        s_do  = g_do;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ack timing.
  assign m0_di = s_di;
  assign m1_di = s_di;

endmodule
